// File: rtl/clkdiv_reset_sequencer.sv
// Releases the resets of a cascaded CLKDIV chain in order once the rPLL has locked and settled.
// Optional lock debounce is enabled by defining LOCK_DEBOUNCE_EN.
module clkdiv_reset_sequencer #(
    parameter int N_STAGES      = 7,
    parameter int SETTLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int LOCK_DEBOUNCE = 64
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                pll_lock,
    input  logic                soft_restart,
    output logic [N_STAGES-1:0] stage_resetn,
    output logic                ready,
    output logic [2:0]          state,
    output logic [7:0]          lost_lock_cnt
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    localparam logic [N_STAGES-1:0] STAGE_LSB  = N_STAGES'(1);
    localparam logic [SET_W-1:0]    SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_END    = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_STAGES - 1);

    if (N_STAGES < 1 || N_STAGES > 16 || SETTLE_CYCLES < 1 || STAGE_GAP < 1 || LOCK_DEBOUNCE < 1) begin : g_bad_param
        $error("clkdiv_reset_sequencer: parameter out of range");
    end

    logic lock_meta;
    logic lock_s;
    logic lock_q;

    // pll_lock comes from the PLL domain, so it is only ever observed through two flops.
    // NOTE: every clocked block uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

`ifdef LOCK_DEBOUNCE_EN
    localparam int DEB_W = (LOCK_DEBOUNCE > 1) ? $clog2(LOCK_DEBOUNCE) : 1;
    localparam logic [DEB_W-1:0] DEB_END = DEB_W'(LOCK_DEBOUNCE - 1);

    logic [DEB_W-1:0] deb_cnt;
    logic             lock_held;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            lock_held <= 1'b0;
        end else if (!lock_s) begin
            deb_cnt   <= '0;
            lock_held <= 1'b0;
        end else if (!lock_held) begin
            if (deb_cnt == DEB_END) lock_held <= 1'b1;
            else                    deb_cnt   <= deb_cnt + 1'b1;
        end
    end

    // Gating with lock_s makes a loss visible the same cycle, only the rise is debounced.
    assign lock_q = lock_s & lock_held;
`else
    assign lock_q = lock_s;
`endif

    logic [SET_W-1:0] settle_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] idx;
    logic             active;
    logic             abort;

    assign active = (state == S_SETTLE) || (state == S_RELEASE) || (state == S_RUN);
    assign abort  = active && (!lock_q || soft_restart);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            stage_resetn  <= '0;
            ready         <= 1'b0;
            lost_lock_cnt <= 8'd0;
            settle_cnt    <= '0;
            gap_cnt       <= '0;
            idx           <= '0;
        end else if (abort) begin
            state        <= S_WAIT_LOCK;
            stage_resetn <= '0;
            ready        <= 1'b0;
            settle_cnt   <= '0;
            gap_cnt      <= '0;
            idx          <= '0;
            // A loss coinciding with a restart still counts once.
            if (!lock_q && lost_lock_cnt != 8'hFF) lost_lock_cnt <= lost_lock_cnt + 8'd1;
        end else begin
            case (state)
                S_IDLE: state <= S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (lock_q) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        state        <= S_RELEASE;
                        idx          <= '0;
                        gap_cnt      <= '0;
                        stage_resetn <= STAGE_LSB;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_cnt == GAP_END) begin
                        gap_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                        end else begin
                            idx          <= idx + 1'b1;
                            stage_resetn <= (stage_resetn << 1) | STAGE_LSB;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_RUN: ;
                default: begin
                    state        <= S_IDLE;
                    stage_resetn <= '0;
                    ready        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_reset_sequencer.sv
// Scoreboard bench for clkdiv_reset_sequencer; expected output snapshots are queued per clock edge.
// Define LOCK_DEBOUNCE_EN for both files to cover the debounced build.
module tb_clkdiv_reset_sequencer;

    localparam int N   = 3;
    localparam int S   = 8;
    localparam int G   = 4;
    localparam int DEB = 5;
`ifdef LOCK_DEBOUNCE_EN
    localparam int D = DEB;
`else
    localparam int D = 0;
`endif

    logic         clkin = 1'b0;
    logic         reset = 1'b1;
    logic         pll_lock = 1'b0;
    logic         soft_restart = 1'b0;
    logic [N-1:0] stage_resetn;
    logic         ready;
    logic [2:0]   state;
    logic [7:0]   lost_lock_cnt;

    clkdiv_reset_sequencer #(
        .N_STAGES(N), .SETTLE_CYCLES(S), .STAGE_GAP(G), .LOCK_DEBOUNCE(DEB)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .soft_restart(soft_restart),
        .stage_resetn(stage_resetn), .ready(ready), .state(state), .lost_lock_cnt(lost_lock_cnt)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] sr;
        logic       rdy;
        logic [2:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [2:0] thermo(input int k);
        return 3'((1 << k) - 1);
    endfunction

    task automatic push(input int at, input logic [2:0] sr, input logic rdy, input logic [2:0] st);
        exp_t e;
        e.at = at; e.sr = sr; e.rdy = rdy; e.st = st; e.cnt = 8'(exp_cnt);
        sb.push_back(e);
    endtask

    // b = edge after which WAIT_LOCK last holds before lock_q is seen; entries beyond offset lim are skipped.
    task automatic push_seq(input int b, input int lim);
        int off;
        if (lim >= 0) push(b, 3'b000, 1'b0, 3'd1);
        if (lim >= 1) push(b + 1, 3'b000, 1'b0, 3'd2);
        for (int k = 0; k < N; k++) begin
            off = S + k * G;
            if (off <= lim)     push(b + off, thermo(k), 1'b0, (k == 0) ? 3'd2 : 3'd3);
            if (off + 1 <= lim) push(b + off + 1, thermo(k + 1), 1'b0, 3'd3);
        end
        off = S + N * G;
        if (off <= lim)     push(b + off, thermo(N), 1'b0, 3'd3);
        if (off + 1 <= lim) push(b + off + 1, thermo(N), 1'b1, 3'd4);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    always @(negedge clkin) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at < cyc) begin
                check($sformatf("missed@%0d", sb[i].at), cyc, sb[i].at);
                sb.delete(i);
            end else if (sb[i].at == cyc) begin
                check($sformatf("stage_resetn@%0d", cyc), stage_resetn, sb[i].sr);
                check($sformatf("ready@%0d", cyc), ready, sb[i].rdy);
                check($sformatf("state@%0d", cyc), state, sb[i].st);
                check($sformatf("lost_lock_cnt@%0d", cyc), lost_lock_cnt, sb[i].cnt);
                sb.delete(i);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, q, b, r;
        int h;
        h = D + 2;

        // Reset values while reset is held.
        tick(3);
        check("rst_stage_resetn", stage_resetn, 0);
        check("rst_ready", ready, 0);
        check("rst_state", state, 0);
        check("rst_cnt", lost_lock_cnt, 0);

        // No lock for 50 cycles: parked in WAIT_LOCK.
        reset = 1'b0;
        r = cyc;
        for (int i = 1; i <= 50; i++) push(r + i, 3'b000, 1'b0, 3'd1);
        tick(52);

        // Lock and full release sequence.
        p = cyc;
        pll_lock = 1'b1;
        push_seq(p + 2 + D, 99);
        tick(2 + D + 25);

        // Lock loss in RUN, then relock.
        p = cyc;
        pll_lock = 1'b0;
        push(p + 2, 3'b111, 1'b1, 3'd4);
        exp_cnt++;
        push(p + 3, 3'b000, 1'b0, 3'd1);
        tick(5);
        p = cyc;
        pll_lock = 1'b1;
        push_seq(p + 2 + D, 99);
        tick(2 + D + 25);

        // Soft restart in RUN re-runs the sequence; restart again while stage_resetn=011.
        q = cyc;
        soft_restart = 1'b1;
        b = q + 1;
        push_seq(b, 14);
        tick(1);
        soft_restart = 1'b0;
        tick(14);
        soft_restart = 1'b1;
        push_seq(b + 15, 99);
        tick(1);
        soft_restart = 1'b0;
        tick(25);

        // Loss and restart sampled on the same edge: counts once.
        p = cyc;
        pll_lock = 1'b0;
        push(p + 2, 3'b111, 1'b1, 3'd4);
        exp_cnt++;
        push(p + 3, 3'b000, 1'b0, 3'd1);
        tick(2);
        soft_restart = 1'b1;
        tick(1);
        soft_restart = 1'b0;
        tick(3);

        // Restart in WAIT_LOCK has no effect.
        q = cyc;
        soft_restart = 1'b1;
        push(q + 1, 3'b000, 1'b0, 3'd1);
        push(q + 2, 3'b000, 1'b0, 3'd1);
        tick(1);
        soft_restart = 1'b0;
        tick(3);

        // 300 losses during SETTLE: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            p = cyc;
            pll_lock = 1'b1;
            push(p + h + 2, 3'b000, 1'b0, 3'd2);
            if (exp_cnt < 255) exp_cnt++;
            push(p + h + 3, 3'b000, 1'b0, 3'd1);
            tick(h);
            pll_lock = 1'b0;
            tick(4);
        end
        check("cnt_saturated", lost_lock_cnt, 255);

`ifdef LOCK_DEBOUNCE_EN
        // Lock glitch: synced lock high 4 cycles, low 1, then high for good.
        p = cyc;
        for (int t = p + 1; t < p + 7 + D; t++) push(t, 3'b000, 1'b0, 3'd1);
        push_seq(p + 7 + D, 99);
        pll_lock = 1'b1;
        tick(4);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(2 + D + 25);
        p = cyc;
        pll_lock = 1'b0;
        push(p + 2, 3'b111, 1'b1, 3'd4);
        if (exp_cnt < 255) exp_cnt++;
        push(p + 3, 3'b000, 1'b0, 3'd1);
        tick(5);
`endif

        // Asynchronous reset in the middle of the release sequence.
        p = cyc;
        pll_lock = 1'b1;
        b = p + 2 + D;
        push_seq(b, 13);
        tick(2 + D + 14);
        #2 reset = 1'b1;
        #1;
        check("async_stage_resetn", stage_resetn, 0);
        check("async_ready", ready, 0);
        check("async_state", state, 0);
        check("async_cnt", lost_lock_cnt, 0);
        exp_cnt = 0;
        tick(2);
        reset = 1'b0;
        r = cyc;
        push(r + 1, 3'b000, 1'b0, 3'd1);
        push(r + 2, 3'b000, 1'b0, 3'd1);
        tick(4);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
